// File: rtl/sd_sector_xfer_pkg.sv
// rtl/sd_sector_xfer_pkg.sv - shared states, SD token/response constants and error codes
package sd_sector_xfer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_TOKEN = 4'd1,
        ST_RD_DATA  = 4'd2,
        ST_RD_CRC   = 4'd3,
        ST_WR_TOKEN = 4'd4,
        ST_WR_FETCH = 4'd5,
        ST_WR_DATA  = 4'd6,
        ST_WR_CRC   = 4'd7,
        ST_WR_RESP  = 4'd8,
        ST_WR_BUSY  = 4'd9,
        ST_DONE     = 4'd10
    } state_t;

    localparam logic [7:0] SD_TOKEN_START = 8'hFE;
    localparam logic [7:0] SD_FILL_BYTE   = 8'hFF;
    localparam logic [7:0] SD_BUSY_BYTE   = 8'h00;
    localparam logic [4:0] SD_RESP_ACCEPT = 5'b00101;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_TOKEN  = 2'b01;
    localparam logic [1:0] ERR_REJECT = 2'b10;
    localparam logic [1:0] ERR_BUSY   = 2'b11;

    // Data error tokens carry three leading zeros.
    function automatic logic is_error_token(input logic [7:0] b);
        return (b[7:5] == 3'b000);
    endfunction

endpackage

// File: rtl/sd_sector_xfer_if.sv
// rtl/sd_sector_xfer_if.sv - SPI byte engine handshake and sector buffer port B
interface sd_sector_xfer_if;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_done;
    logic [7:0]  spi_rx;
    logic [7:0]  address_b;
    logic [15:0] data_b;
    logic        wren_b;
    logic [15:0] q_b;

    modport master (
        output spi_start, spi_tx, address_b, data_b, wren_b,
        input  spi_done, spi_rx, q_b
    );

    modport slave (
        input  spi_start, spi_tx, address_b, data_b, wren_b,
        output spi_done, spi_rx, q_b
    );
endinterface

// File: rtl/sd_sector_xfer_byte_seq.sv
// rtl/sd_sector_xfer_byte_seq.sv - one-byte-outstanding SPI launcher with a 10-bit byte counter
module sd_byte_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_i,
    input  logic [7:0] tx_i,
    input  logic       clr_i,
    output logic       byte_done_o,
    output logic [9:0] count_o,
    output logic       spi_start_o,
    output logic [7:0] spi_tx_o,
    input  logic       spi_done_i
);

    logic       busy_q, busy_d;
    logic       start_q, start_d;
    logic [7:0] tx_q, tx_d;
    logic [9:0] cnt_q, cnt_d;

    // A request is only taken once the previous spi_done has retired, which
    // pushes the next spi_start at least one cycle past spi_done.
    always_comb begin
        busy_d  = busy_q;
        start_d = 1'b0;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        if (!busy_q) begin
            if (req_i) begin
                busy_d  = 1'b1;
                start_d = 1'b1;
                tx_d    = tx_i;
            end
        end else if (spi_done_i) begin
            busy_d = 1'b0;
            cnt_d  = cnt_q + 10'd1;
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            tx_q    <= 8'hFF;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_done_o = busy_q & spi_done_i;
    assign count_o     = cnt_q;
    assign spi_start_o = start_q;
    assign spi_tx_o    = tx_q;

endmodule

// File: rtl/sd_sector_xfer.sv
// rtl/sd_sector_xfer.sv - SD sector mover between the SPI byte engine and sector buffer port B
module sd_sector_xfer
    import sd_sector_xfer_pkg::*;
#(
    parameter logic [15:0] TOKEN_TIMEOUT = 16'd50000,
    parameter logic [19:0] BUSY_TIMEOUT  = 20'd500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic              dir_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o,
    sd_sector_xfer_if.master  bus
);

    state_t      state_q, state_d;
    logic [19:0] poll_q, poll_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] word_q, word_d;
    logic        fetch_q, fetch_d;
    logic        wren_q, wren_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  err_q, err_d;

    logic        seq_req;
    logic        seq_clr;
    logic [7:0]  seq_tx;
    logic        seq_done;
    logic [9:0]  seq_cnt;
    logic        seq_spi_start;
    logic [7:0]  seq_spi_tx;

    logic [7:0]  rx;
    logic [19:0] poll_inc;
    logic        tok_expired;
    logic        busy_expired;

    assign rx           = bus.spi_rx;
    assign poll_inc     = poll_q + 20'd1;
    assign tok_expired  = (poll_inc >= {4'd0, TOKEN_TIMEOUT});
    assign busy_expired = (poll_inc >= BUSY_TIMEOUT);

    sd_byte_seq u_seq (
        .clock       (clock),
        .reset       (reset),
        .req_i       (seq_req),
        .tx_i        (seq_tx),
        .clr_i       (seq_clr),
        .byte_done_o (seq_done),
        .count_o     (seq_cnt),
        .spi_start_o (seq_spi_start),
        .spi_tx_o    (seq_spi_tx),
        .spi_done_i  (bus.spi_done)
    );

    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        word_d  = word_q;
        fetch_d = 1'b0;
        wren_d  = 1'b0;
        wdata_d = wdata_q;
        err_d   = err_q;
        seq_req = 1'b0;
        seq_tx  = SD_FILL_BYTE;
        seq_clr = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;

        // Address steps after each buffer write but parks on the last word.
        if (wren_q && (addr_q != 8'hFF)) begin
            addr_d = addr_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = dir_i ? ST_WR_TOKEN : ST_RD_TOKEN;
                    poll_d  = '0;
                    addr_d  = '0;
                    err_d   = ERR_OK;
                    seq_clr = 1'b1;
                end
            end

            ST_RD_TOKEN: begin
                seq_req = 1'b1;
                if (seq_done) begin
                    if (rx == SD_TOKEN_START) begin
                        state_d = ST_RD_DATA;
                        seq_clr = 1'b1;
                    end else if (is_error_token(rx)) begin
                        state_d = ST_DONE;
                        err_d   = ERR_TOKEN;
                    end else if ((rx == SD_FILL_BYTE) && tok_expired) begin
                        state_d = ST_DONE;
                        err_d   = ERR_TOKEN;
                    end else begin
                        poll_d = poll_inc;
                    end
                end
            end

            ST_RD_DATA: begin
                seq_req = 1'b1;
                if (seq_done) begin
                    if (!seq_cnt[0]) begin
                        lo_d = rx;
                    end else begin
                        wren_d  = 1'b1;
                        wdata_d = {rx, lo_q};
                    end
                    if (seq_cnt == 10'd511) begin
                        state_d = ST_RD_CRC;
                        seq_clr = 1'b1;
                    end
                end
            end

            ST_RD_CRC: begin
                seq_req = 1'b1;
                if (seq_done && seq_cnt[0]) begin
                    state_d = ST_DONE;
                end
            end

            ST_WR_TOKEN: begin
                seq_req = 1'b1;
                seq_tx  = SD_TOKEN_START;
                if (seq_done) begin
                    state_d = ST_WR_FETCH;
                    addr_d  = '0;
                    seq_clr = 1'b1;
                end
            end

            // First cycle presents the address, second captures q_b.
            ST_WR_FETCH: begin
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    word_d  = bus.q_b;
                    state_d = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                seq_req = 1'b1;
                seq_tx  = seq_cnt[0] ? word_q[15:8] : word_q[7:0];
                if (seq_done && seq_cnt[0]) begin
                    if (addr_q != 8'hFF) begin
                        addr_d  = addr_q + 8'd1;
                        state_d = ST_WR_FETCH;
                    end else begin
                        state_d = ST_WR_CRC;
                        seq_clr = 1'b1;
                    end
                end
            end

            ST_WR_CRC: begin
                seq_req = 1'b1;
                if (seq_done && seq_cnt[0]) begin
                    state_d = ST_WR_RESP;
                    poll_d  = '0;
                end
            end

            ST_WR_RESP: begin
                seq_req = 1'b1;
                if (seq_done) begin
                    if (rx == SD_FILL_BYTE) begin
                        if (tok_expired) begin
                            state_d = ST_DONE;
                            err_d   = ERR_TOKEN;
                        end else begin
                            poll_d = poll_inc;
                        end
                    end else if (rx[4:0] == SD_RESP_ACCEPT) begin
                        state_d = ST_WR_BUSY;
                        poll_d  = '0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = ERR_REJECT;
                    end
                end
            end

            ST_WR_BUSY: begin
                seq_req = 1'b1;
                if (seq_done) begin
                    if (rx == SD_BUSY_BYTE) begin
                        if (busy_expired) begin
                            state_d = ST_DONE;
                            err_d   = ERR_BUSY;
                        end else begin
                            poll_d = poll_inc;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                busy_o  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            poll_q  <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            word_q  <= '0;
            fetch_q <= 1'b0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            word_q  <= word_d;
            fetch_q <= fetch_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign err_o         = err_q;
    assign bus.spi_start = seq_spi_start;
    assign bus.spi_tx    = seq_spi_tx;
    assign bus.address_b = addr_q;
    assign bus.data_b    = wdata_q;
    assign bus.wren_b    = wren_q;

endmodule

// File: tb/tb_sd_sector_xfer.sv
// tb/tb_sd_sector_xfer.sv - randomized self-checking bench with card and sector buffer models
module tb_sd_sector_xfer;
    import sd_sector_xfer_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_i;
    logic       dir_i;
    logic       busy_o;
    logic       done_o;
    logic [1:0] err_o;

    sd_sector_xfer_if bus();

    sd_sector_xfer #(
        .TOKEN_TIMEOUT (16'd8),
        .BUSY_TIMEOUT  (20'd16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start_i (start_i),
        .dir_i   (dir_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Card model: answers each spi_start after a random delay from rx_q (or rx_default).
    logic [7:0] rx_q[$];
    logic [7:0] rx_default;
    logic [7:0] tx_log[$];
    int         spi_violations;
    logic [7:0] card_tx;
    int         card_lat;

    initial begin
        bus.spi_done = 1'b0;
        bus.spi_rx   = 8'hFF;
        forever begin
            @(negedge clock);
            bus.spi_done = 1'b0;
            if (bus.spi_start === 1'b1) begin
                card_tx = bus.spi_tx;
                tx_log.push_back(card_tx);
                card_lat = $urandom_range(0, 3);
                for (int k = 0; k < card_lat; k++) begin
                    @(negedge clock);
                    if (bus.spi_start !== 1'b0 || bus.spi_tx !== card_tx) spi_violations++;
                end
                bus.spi_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : rx_default;
                bus.spi_done = 1'b1;
            end
        end
    end

    // Sector buffer model: one-cycle read latency, writes logged.
    logic [15:0] mem[256];
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic [7:0]  rd_bytes[512];

    always @(posedge clock) bus.q_b <= mem[bus.address_b];

    always @(negedge clock) begin
        if (bus.wren_b === 1'b1) begin
            wr_addr.push_back(bus.address_b);
            wr_data.push_back(bus.data_b);
        end
    end

    task automatic prep(input logic [7:0] dflt);
        repeat (8) @(negedge clock);
        rx_q.delete();
        tx_log.delete();
        wr_addr.delete();
        wr_data.delete();
        rx_default     = dflt;
        spi_violations = 0;
    endtask

    task automatic run_xfer(input logic d, output logic [1:0] err_seen, output logic got_done);
        @(negedge clock);
        start_i = 1'b1;
        dir_i   = d;
        @(negedge clock);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1'b1);
        got_done = 1'b0;
        err_seen = 2'b00;
        for (int n = 0; n < 30000 && !got_done; n++) begin
            if (done_o === 1'b1) begin
                got_done = 1'b1;
                err_seen = err_o;
                check("busy_low_at_done", busy_o, 1'b0);
            end else begin
                @(negedge clock);
            end
        end
        check("done_seen", got_done, 1'b1);
    endtask

    task automatic read_case(input string tag, input int polls);
        logic [1:0]  e;
        logic        dn;
        int          mism;
        int          nonff;
        logic [23:0] got;
        logic [23:0] exp;
        prep(8'hFF);
        for (int i = 0; i < polls; i++) rx_q.push_back(8'hFF);
        rx_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) rx_q.push_back(rd_bytes[i]);
        rx_q.push_back(8'($urandom));
        rx_q.push_back(8'($urandom));
        run_xfer(1'b0, e, dn);
        check({tag, "_err"}, e, 2'b00);
        check({tag, "_nwr"}, wr_addr.size(), 256);
        mism = 0;
        for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
            exp = {i[7:0], rd_bytes[2*i+1], rd_bytes[2*i]};
            got = {wr_addr[i], wr_data[i]};
            if (got !== exp) begin
                if (mism == 0) check({tag, "_word"}, got, exp);
                mism++;
            end
        end
        check({tag, "_word_mism"}, mism, 0);
        check({tag, "_ntx"}, tx_log.size(), polls + 1 + 512 + 2);
        nonff = 0;
        foreach (tx_log[i]) if (tx_log[i] !== 8'hFF) nonff++;
        check({tag, "_tx_nonff"}, nonff, 0);
        check({tag, "_spi_rule"}, spi_violations, 0);
    endtask

    task automatic write_case(input string tag, input int resp_polls, input logic [7:0] resp,
                              input int busy_polls, input logic [7:0] dflt,
                              input logic [1:0] exp_err, input int exp_post);
        logic [1:0] e;
        logic       dn;
        int         mism;
        logic [7:0] exp_tx[$];
        prep(dflt);
        repeat (515) rx_q.push_back(8'hFF);
        repeat (resp_polls) rx_q.push_back(8'hFF);
        rx_q.push_back(resp);
        repeat (busy_polls) rx_q.push_back(8'h00);
        exp_tx.push_back(8'hFE);
        for (int n = 0; n < 256; n++) begin
            exp_tx.push_back(mem[n][7:0]);
            exp_tx.push_back(mem[n][15:8]);
        end
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hFF);
        repeat (exp_post) exp_tx.push_back(8'hFF);
        run_xfer(1'b1, e, dn);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_nwr"}, wr_addr.size(), 0);
        check({tag, "_ntx"}, tx_log.size(), exp_tx.size());
        mism = 0;
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
            if (tx_log[i] !== exp_tx[i]) begin
                if (mism == 0) check({tag, "_txbyte"}, {i[15:0], tx_log[i]}, {i[15:0], exp_tx[i]});
                mism++;
            end
        end
        check({tag, "_tx_mism"}, mism, 0);
        check({tag, "_spi_rule"}, spi_violations, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] e;
        logic       dn;
        int         rp;
        int         bp;
        int         n;
        int         snap;
        int         act;

        reset      = 1'b1;
        start_i    = 1'b0;
        dir_i      = 1'b0;
        rx_default = 8'hFF;
        spi_violations = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 2'b00);
        check("rst_spi_start", bus.spi_start, 1'b0);
        check("rst_spi_tx", bus.spi_tx, 8'hFF);
        check("rst_addr", bus.address_b, 8'h00);
        check("rst_wren", bus.wren_b, 1'b0);
        check("rst_state", dut.state_q, ST_IDLE);
        reset = 1'b0;

        for (int i = 0; i < 512; i++) rd_bytes[i] = i[7:0];
        read_case("rd_spec", 2);
        check("rd_spec_word0", (wr_data.size() > 0) ? wr_data[0] : 16'hxxxx, 16'h0100);
        check("rd_spec_word255", (wr_data.size() > 255) ? wr_data[255] : 16'hxxxx, 16'hFFFE);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 512; i++) rd_bytes[i] = 8'($urandom);
            read_case("rd_rand", $urandom_range(0, 6));
        end

        prep(8'hFF);
        run_xfer(1'b0, e, dn);
        check("rd_tmo_err", e, 2'b01);
        check("rd_tmo_polls", tx_log.size(), 8);
        check("rd_tmo_nwr", wr_addr.size(), 0);
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        check("start_at_done_ignored", busy_o, 1'b0);
        check("err_held", err_o, 2'b01);

        prep(8'hFF);
        rx_q.push_back(8'hFF);
        rx_q.push_back(8'h08);
        run_xfer(1'b0, e, dn);
        check("rd_errtok_err", e, 2'b01);
        check("rd_errtok_ntx", tx_log.size(), 2);
        check("rd_errtok_nwr", wr_addr.size(), 0);

        for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0]};
        write_case("wr_spec", 0, 8'hE5, 3, 8'hFF, 2'b00, 1 + 3 + 1);

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rp = $urandom_range(0, 5);
        bp = $urandom_range(0, 14);
        write_case("wr_rand", rp, 8'hE5, bp, 8'hFF, 2'b00, rp + 1 + bp + 1);

        rp = $urandom_range(0, 3);
        write_case("wr_rej", rp, 8'h0B, 0, 8'hFF, 2'b10, rp + 1);

        write_case("wr_stuck", 0, 8'hE5, 0, 8'h00, 2'b11, 1 + 16);

        prep(8'hFF);
        rx_q.push_back(8'hFE);
        repeat (514) rx_q.push_back(8'($urandom));
        @(negedge clock);
        start_i = 1'b1;
        dir_i   = 1'b0;
        @(negedge clock);
        start_i = 1'b0;
        n = 0;
        while (tx_log.size() < 102 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("rst_reach_byte100", tx_log.size() >= 102, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_busy", busy_o, 1'b0);
        check("rst_mid_state", dut.state_q, ST_IDLE);
        snap = tx_log.size();
        act  = 0;
        repeat (12) begin
            if (bus.spi_start !== 1'b0 || bus.wren_b !== 1'b0) act++;
            @(negedge clock);
        end
        check("rst_mid_quiet", act, 0);
        check("rst_mid_no_tx", tx_log.size(), snap);

        for (int i = 0; i < 512; i++) rd_bytes[i] = 8'($urandom);
        read_case("rd_after_rst", $urandom_range(0, 6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
